// File: rtl/fht_unload_pkg.sv
// fht_unload_pkg -- shared types and helpers for the FHT result unloader.
//   fetch_state_t : states of the row-fetch FSM in fht_unloader
//   NUM_BANKS     : number of result banks read in parallel per row
//   bit_rev()     : reverse the low `width` bits of a value
package fht_unload_pkg;

  localparam int NUM_BANKS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_STALL,
    ST_END
  } fetch_state_t;

  // Shift-based reversal keeps every index constant, so any width up to 32 works.
  function automatic logic [31:0] bit_rev(input logic [31:0] value, input int width);
    logic [31:0] src;
    logic [31:0] res;
    src = value;
    res = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        res = {res[30:0], src[0]};
        src = {1'b0, src[31:1]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fht_unload_rowbuf.sv
// fht_unload_rowbuf -- ping-pong pair of 4-word row buffers.
// A capture writes all four banks of one row into the buffer under the
// capture pointer; the emit side serializes the buffer under the emit pointer
// one word per valid/ready handshake, bank0 first.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   cap_en         write cap_data into the capture buffer (must be free)
//   cap_data       one row, element b = bank b
//   emit_ready     consumer ready
//   emit_valid     current emit buffer holds unsent words
//   emit_data      word at emit_bank of the emit buffer (0 when not valid)
//   emit_bank      bank index of the word being presented
//   emit_release   bank3 handshake this cycle: emit buffer is freed
//   full_cnt       number of buffers currently holding unsent data
module fht_unload_rowbuf
  import fht_unload_pkg::*;
#(
  parameter int D_BIT = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cap_en,
  input  logic [NUM_BANKS-1:0][D_BIT-1:0]   cap_data,
  input  logic                              emit_ready,
  output logic                              emit_valid,
  output logic [D_BIT-1:0]                  emit_data,
  output logic [1:0]                        emit_bank,
  output logic                              emit_release,
  output logic [1:0]                        full_cnt
);

  logic [D_BIT-1:0] row_mem [2][NUM_BANKS];
  logic [1:0]       full_reg;
  logic             wr_sel_reg;
  logic             rd_sel_reg;
  logic [1:0]       bank_reg;
  logic             hs;

  assign emit_valid   = full_reg[rd_sel_reg];
  assign hs           = emit_valid & emit_ready;
  assign emit_release = hs & (bank_reg == 2'(NUM_BANKS - 1));
  assign emit_bank    = bank_reg;
  assign emit_data    = emit_valid ? row_mem[rd_sel_reg][bank_reg] : '0;
  assign full_cnt     = {1'b0, full_reg[0]} + {1'b0, full_reg[1]};

  // Data words carry no reset; emit_data is gated by the valid flag instead.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        row_mem[wr_sel_reg][b] <= cap_data[b];
      end
    end
  end

  // Capture and release never touch the same buffer in one cycle: the capture
  // target is always a free buffer, the released one is always full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_reg   <= '0;
      wr_sel_reg <= 1'b0;
      rd_sel_reg <= 1'b0;
      bank_reg   <= '0;
    end else begin
      if (cap_en) begin
        full_reg[wr_sel_reg] <= 1'b1;
        wr_sel_reg           <= ~wr_sel_reg;
      end
      if (hs) begin
        bank_reg <= bank_reg + 2'd1;
      end
      if (emit_release) begin
        full_reg[rd_sel_reg] <= 1'b0;
        rd_sel_reg           <= ~rd_sel_reg;
      end
    end
  end

endmodule

// File: rtl/fht_unloader.sv
// fht_unloader -- reads the four result banks of fht_top row by row and
// streams the samples out in natural order (index = 4*row + bank) on a
// valid/ready interface. Optional bit-reversed row addressing.
// Optional feature macro: FHT_UNLOAD_SCALE_EN (adds SCALE_SH and iSCALE:
// saturating left shift of each sample, applied at capture).
// Ports:
//   iCLK, iRESET     clock, synchronous active-low reset
//   iSTART           one-cycle pulse, starts a pass when idle
//   iBITREV          latched on start: 1 = address bitrev(row), 0 = row
//   iSCALE           (FHT_UNLOAD_SCALE_EN only) latched on start
//   oADDR_RD         row read address to all four banks
//   iDATA_0..3       bank read data, valid RD_LAT cycles after the address
//   oDATA, oVALID    output sample stream, held while iREADY=0
//   iREADY           consumer ready
//   oLAST            marks sample N-1
//   oBUSY            pass in progress
module fht_unloader
  import fht_unload_pkg::*;
#(
  parameter int D_BIT  = 16,
  parameter int A_BIT  = 8,
  parameter int RD_LAT = 2
`ifdef FHT_UNLOAD_SCALE_EN
  , parameter int SCALE_SH = 9
`endif
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  input  logic             iBITREV,
`ifdef FHT_UNLOAD_SCALE_EN
  input  logic             iSCALE,
`endif
  output logic [A_BIT-1:0] oADDR_RD,
  input  logic [D_BIT-1:0] iDATA_0,
  input  logic [D_BIT-1:0] iDATA_1,
  input  logic [D_BIT-1:0] iDATA_2,
  input  logic [D_BIT-1:0] iDATA_3,
  output logic [D_BIT-1:0] oDATA,
  output logic             oVALID,
  input  logic             iREADY,
  output logic             oLAST,
  output logic             oBUSY
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [A_BIT-1:0] LAST_ROW = '1;

  fetch_state_t                   state_reg;
  fetch_state_t                   state_next;
  logic [A_BIT-1:0]               row_reg;
  logic [CW-1:0]                  wait_cnt_reg;
  logic                           bitrev_reg;
  logic                           cap_en;
  logic                           last_hs;
  logic [NUM_BANKS-1:0][D_BIT-1:0] ram_word;
  logic [NUM_BANKS-1:0][D_BIT-1:0] cap_word;
  logic                           emit_valid;
  logic [D_BIT-1:0]               emit_data;
  logic [1:0]                     emit_bank;
  logic                           emit_release;
  logic [1:0]                     full_cnt;

  assign ram_word = {iDATA_3, iDATA_2, iDATA_1, iDATA_0};

`ifdef FHT_UNLOAD_SCALE_EN
  localparam int WW = D_BIT + SCALE_SH;
  logic scale_reg;

  // The result fits when the bits above the D_BIT sign position all agree
  // with it; otherwise clamp towards the sign of the wide value.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_scale
    logic signed [WW-1:0] wide;
    assign wide = WW'($signed(ram_word[gi])) <<< SCALE_SH;
    assign cap_word[gi] = !scale_reg ? ram_word[gi] :
        ((&wide[WW-1:D_BIT-1]) || !(|wide[WW-1:D_BIT-1])) ? wide[D_BIT-1:0] :
        wide[WW-1] ? {1'b1, {(D_BIT-1){1'b0}}} : {1'b0, {(D_BIT-1){1'b1}}};
  end
`else
  assign cap_word = ram_word;
`endif

  fht_unload_rowbuf #(
    .D_BIT (D_BIT)
  ) u_rowbuf (
    .clk          (iCLK),
    .rst_n        (iRESET),
    .cap_en       (cap_en),
    .cap_data     (cap_word),
    .emit_ready   (iREADY),
    .emit_valid   (emit_valid),
    .emit_data    (emit_data),
    .emit_bank    (emit_bank),
    .emit_release (emit_release),
    .full_cnt     (full_cnt)
  );

  assign oVALID  = emit_valid;
  assign oDATA   = emit_data;
  assign last_hs = oLAST & iREADY;

  // State register
  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state. Only one fetch is ever outstanding, so at capture time at most
  // one buffer is full; another fetch may start right away if that buffer is
  // empty or is being released in this same cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (iSTART) state_next = ST_FETCH;
      ST_FETCH: state_next = ST_WAIT;
      ST_WAIT: begin
        if (cap_en) begin
          if (row_reg == LAST_ROW) begin
            state_next = ST_END;
          end else if (full_cnt == 2'd0 || (full_cnt == 2'd1 && emit_release)) begin
            state_next = ST_FETCH;
          end else begin
            state_next = ST_STALL;
          end
        end
      end
      ST_STALL: if (full_cnt != 2'd2 || emit_release) state_next = ST_FETCH;
      ST_END:   if (last_hs) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs. In END no further captures happen, so a single full buffer is
  // necessarily the final row.
  always_comb begin
    cap_en   = (state_reg == ST_WAIT) && (wait_cnt_reg == CW'(RD_LAT - 1));
    oBUSY    = (state_reg != ST_IDLE);
    oLAST    = emit_valid && (state_reg == ST_END) && (full_cnt == 2'd1) &&
               (emit_bank == 2'(NUM_BANKS - 1));
    oADDR_RD = bitrev_reg ? A_BIT'(bit_rev(32'(row_reg), A_BIT)) : row_reg;
  end

  // Row counter, read-latency counter and per-pass options
  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      row_reg      <= '0;
      wait_cnt_reg <= '0;
      bitrev_reg   <= 1'b0;
`ifdef FHT_UNLOAD_SCALE_EN
      scale_reg    <= 1'b0;
`endif
    end else begin
      if (state_reg == ST_IDLE && iSTART) begin
        row_reg    <= '0;
        bitrev_reg <= iBITREV;
`ifdef FHT_UNLOAD_SCALE_EN
        scale_reg  <= iSCALE;
`endif
      end
      if (state_reg == ST_FETCH) begin
        wait_cnt_reg <= '0;
      end else if (state_reg == ST_WAIT) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
      if (cap_en) begin
        row_reg <= row_reg + 1'b1;
      end
    end
  end

endmodule
